// File: rtl/rk_tape_player.sv
// rk_tape_player: plays a byte file (leader, sync byte, payload, trailer) as a
// phase-encoded cassette waveform on tape_out for the PPA1 tapein line.
// Each bit is two half-cells, ~bit then bit, sent MSB first. All cell timing
// is paced by the ce_tape strobe.
module rk_tape_player #(
    parameter int         HALF_CELL    = 600,
    parameter int         LEADER_BYTES = 256,
    parameter logic [7:0] SYNC_BYTE    = 8'hE6,
    parameter int         TRAIL_BYTES  = 2
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       ce_tape,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       data_last,
    output logic       data_ready,
    output logic       tape_out,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam int              CW          = (HALF_CELL > 1) ? $clog2(HALF_CELL) : 1;
    localparam logic [CW-1:0]   CNT_LAST    = CW'(HALF_CELL - 1);
    localparam logic [15:0]     LEADER_LOAD = 16'(LEADER_BYTES - 1);
    localparam logic [7:0]      TRAIL_LOAD  = (TRAIL_BYTES > 0) ? 8'(TRAIL_BYTES - 1) : 8'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEADER,
        S_SYNC,
        S_DATA,
        S_TRAIL
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic            half;
    logic [7:0]      shreg;
    logic [15:0]     leader_cnt;
    logic [7:0]      trail_cnt;
    logic            last_flag;
    logic            tick;

    // Terminal ce_tape tick of the current half-cell.
    assign tick = ce_tape && (cnt == CNT_LAST);
    assign busy = (state != S_IDLE);

    // Playback FSM: half-cell timing, bit serialisation and byte sourcing.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= 3'd0;
            half       <= 1'b0;
            shreg      <= 8'h00;
            leader_cnt <= 16'd0;
            trail_cnt  <= 8'd0;
            last_flag  <= 1'b0;
            tape_out   <= 1'b0;
            data_ready <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            done       <= 1'b0;
            if (stop) begin
                // Abort wins over everything, including a simultaneous start.
                state    <= S_IDLE;
                tape_out <= 1'b0;
                cnt      <= '0;
                half     <= 1'b0;
                bit_idx  <= 3'd0;
            end else if (state == S_IDLE) begin
                if (start) begin
                    state      <= S_LEADER;
                    shreg      <= 8'h00;
                    cnt        <= '0;
                    half       <= 1'b0;
                    bit_idx    <= 3'd7;
                    leader_cnt <= LEADER_LOAD;
                    last_flag  <= 1'b0;
                    underrun   <= 1'b0;
                    tape_out   <= 1'b1;
                end
            end else if (tick) begin
                cnt <= '0;
                if (!half) begin
                    // Second half of the bit shows the bit value itself.
                    half     <= 1'b1;
                    tape_out <= shreg[7];
                end else if (bit_idx != 3'd0) begin
                    // Next bit: first half is the inverted bit.
                    half     <= 1'b0;
                    bit_idx  <= bit_idx - 3'd1;
                    shreg    <= {shreg[6:0], 1'b0};
                    tape_out <= ~shreg[6];
                end else begin
                    // End of byte: pick the next byte source.
                    half    <= 1'b0;
                    bit_idx <= 3'd7;
                    case (state)
                        S_LEADER: begin
                            if (leader_cnt == 16'd0) begin
                                state    <= S_SYNC;
                                shreg    <= SYNC_BYTE;
                                tape_out <= ~SYNC_BYTE[7];
                            end else begin
                                leader_cnt <= leader_cnt - 16'd1;
                                shreg      <= 8'h00;
                                tape_out   <= 1'b1;
                            end
                        end
                        S_SYNC, S_DATA: begin
                            if (state == S_DATA && last_flag) begin
                                if (TRAIL_BYTES == 0) begin
                                    state    <= S_IDLE;
                                    tape_out <= 1'b0;
                                    done     <= 1'b1;
                                end else begin
                                    state     <= S_TRAIL;
                                    trail_cnt <= TRAIL_LOAD;
                                    shreg     <= 8'h00;
                                    tape_out  <= 1'b1;
                                end
                            end else if (data_valid) begin
                                state      <= S_DATA;
                                shreg      <= data_in;
                                last_flag  <= data_last;
                                data_ready <= 1'b1;
                                tape_out   <= ~data_in[7];
                            end else begin
                                // Upstream had nothing at the load point.
                                state    <= S_IDLE;
                                underrun <= 1'b1;
                                tape_out <= 1'b0;
                            end
                        end
                        S_TRAIL: begin
                            if (trail_cnt == 8'd0) begin
                                state    <= S_IDLE;
                                tape_out <= 1'b0;
                                done     <= 1'b1;
                            end else begin
                                trail_cnt <= trail_cnt - 8'd1;
                                shreg     <= 8'h00;
                                tape_out  <= 1'b1;
                            end
                        end
                        default: begin
                            state    <= S_IDLE;
                            tape_out <= 1'b0;
                        end
                    endcase
                end
            end else if (ce_tape) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule
